cacheline_adaptor: RTL and testbench



---
 rtl/cacheline_adaptor.sv | 244 ++++++++++++++++++++++++
 tb/tb_cacheline_adaptor.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// cacheline_adaptor
//   Memory-side responder for the L2 cache line port. Accepts one full-line
//   read or write, runs it as a num_beats-beat burst on the physical memory
//   bus, then pulses resp_o to the cache for one cycle. One transaction is in
//   flight at a time; a write line is held in a single line buffer.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   address_i  line address from cache (offset bits ignored)
//   line_i     write line from cache
//   line_o     read line to cache (held until the next read's first beat)
//   read_i     cache line read request
//   write_i    cache line write request (wins over read_i)
//   resp_o     one-cycle completion pulse to cache
//   address_o  burst base address to memory, offset bits zero
//   burst_i    read beat from memory
//   burst_o    write beat to memory
//   read_o     burst read request
//   write_o    burst write request
//   resp_i     memory beat acknowledge / valid
//   rd_count   completed reads, wraps mod 2^32 (CACHELINE_ADAPTOR_PERF_EN only)
//   wr_count   completed writes, wraps mod 2^32 (CACHELINE_ADAPTOR_PERF_EN only)
//
// Build options
//   CACHELINE_ADAPTOR_PERF_EN  adds the rd_count / wr_count counters and ports.
// -----------------------------------------------------------------------------
module cacheline_adaptor #(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_line   = 256,
    parameter int unsigned s_beat   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       address_i,
    input  logic [s_line-1:0] line_i,
    output logic [s_line-1:0] line_o,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    output logic [31:0]       address_o,
    input  logic [s_beat-1:0] burst_i,
    output logic [s_beat-1:0] burst_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
`ifdef CACHELINE_ADAPTOR_PERF_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count
`endif
);

    localparam int unsigned NUM_BEATS = s_line / s_beat;
    localparam int unsigned CNT_W     = $clog2(NUM_BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);
    localparam logic [31:0] OFFSET_MASK = 32'((64'd1 << s_offset) - 64'd1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [CNT_W-1:0]   r_cnt;
    logic [s_line-1:0]  r_wline;
    logic [31:0]        r_address_o;
    logic [s_line-1:0]  r_line_o;
    logic [s_beat-1:0]  r_burst_o;
    logic               r_read_o;
    logic               r_write_o;
    logic               r_resp_o;

    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [s_line-1:0]  w_wline_nxt;
    logic [31:0]        w_address_nxt;
    logic [s_line-1:0]  w_line_nxt;
    logic [s_beat-1:0]  w_burst_nxt;
    logic               w_read_nxt;
    logic               w_write_nxt;
    logic               w_resp_nxt;

    logic [CNT_W-1:0]   w_cnt_inc;
    logic [31:0]        w_line_addr;
    logic               w_last_ack;

    assign w_cnt_inc   = r_cnt + CNT_W'(1);
    assign w_line_addr = address_i & ~OFFSET_MASK;
    assign w_last_ack  = resp_i && (r_cnt == LAST_BEAT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; write has priority over read in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_state_nxt = WR_BURST;
                end else if (read_i) begin
                    w_state_nxt = RD_BURST;
                end
            end
            RD_BURST: begin
                if (w_last_ack) begin
                    w_state_nxt = DONE;
                end
            end
            WR_BURST: begin
                if (w_last_ack) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output / datapath next values; registered below so every output is a flop
    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_wline_nxt   = r_wline;
        w_address_nxt = r_address_o;
        w_line_nxt    = r_line_o;
        w_burst_nxt   = r_burst_o;
        w_read_nxt    = 1'b0;
        w_write_nxt   = 1'b0;
        w_resp_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (write_i) begin
                    w_address_nxt = w_line_addr;
                    w_wline_nxt   = line_i;
                    w_cnt_nxt     = '0;
                    w_burst_nxt   = line_i[s_beat-1:0];
                    w_write_nxt   = 1'b1;
                end else if (read_i) begin
                    w_address_nxt = w_line_addr;
                    w_cnt_nxt     = '0;
                    w_read_nxt    = 1'b1;
                end
            end
            RD_BURST: begin
                w_read_nxt = 1'b1;
                if (resp_i) begin
                    // Beat 0 lands in the least significant slice
                    w_line_nxt[r_cnt*s_beat +: s_beat] = burst_i;
                    w_cnt_nxt = w_cnt_inc;
                    if (r_cnt == LAST_BEAT) begin
                        w_read_nxt = 1'b0;
                        w_resp_nxt = 1'b1;
                    end
                end
            end
            WR_BURST: begin
                w_write_nxt = 1'b1;
                if (resp_i) begin
                    // Present the following beat; counter wraps to 0 after the last
                    w_cnt_nxt   = w_cnt_inc;
                    w_burst_nxt = r_wline[w_cnt_inc*s_beat +: s_beat];
                    if (r_cnt == LAST_BEAT) begin
                        w_write_nxt = 1'b0;
                        w_resp_nxt  = 1'b1;
                    end
                end
            end
            DONE: begin
                w_resp_nxt = 1'b0;
            end
            default: begin
                w_resp_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_wline     <= '0;
            r_address_o <= '0;
            r_line_o    <= '0;
            r_burst_o   <= '0;
            r_read_o    <= 1'b0;
            r_write_o   <= 1'b0;
            r_resp_o    <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_wline     <= w_wline_nxt;
            r_address_o <= w_address_nxt;
            r_line_o    <= w_line_nxt;
            r_burst_o   <= w_burst_nxt;
            r_read_o    <= w_read_nxt;
            r_write_o   <= w_write_nxt;
            r_resp_o    <= w_resp_nxt;
        end
    end

    assign line_o    = r_line_o;
    assign address_o = r_address_o;
    assign burst_o   = r_burst_o;
    assign read_o    = r_read_o;
    assign write_o   = r_write_o;
    assign resp_o    = r_resp_o;

`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic [31:0] r_rd_count;
    logic [31:0] r_wr_count;

    // Completion counters bump on the same edge that raises resp_o
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (w_resp_nxt) begin
            if (r_state == RD_BURST) begin
                r_rd_count <= r_rd_count + 32'd1;
            end else begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// -----------------------------------------------------------------------------
// tb_cacheline_adaptor
//   Directed, table-driven bench for cacheline_adaptor. Each table row gives
//   the inputs held for one clock cycle and the outputs expected after that
//   cycle's rising edge. Inputs change and outputs are sampled on the falling
//   edge. Asynchronous reset mid-burst and the optional perf counters are
//   exercised with short hand-written sequences.
// -----------------------------------------------------------------------------
module tb_cacheline_adaptor;

    logic         clk;
    logic         rst;
    logic [31:0]  address_i;
    logic [255:0] line_i;
    logic [255:0] line_o;
    logic         read_i;
    logic         write_i;
    logic         resp_o;
    logic [31:0]  address_o;
    logic [63:0]  burst_i;
    logic [63:0]  burst_o;
    logic         read_o;
    logic         write_o;
    logic         resp_i;
`ifdef CACHELINE_ADAPTOR_PERF_EN
    logic [31:0]  rd_count;
    logic [31:0]  wr_count;
`endif

    cacheline_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .read_i    (read_i),
        .write_i   (write_i),
        .resp_o    (resp_o),
        .address_o (address_o),
        .burst_i   (burst_i),
        .burst_o   (burst_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .resp_i    (resp_i)
`ifdef CACHELINE_ADAPTOR_PERF_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         rd;
        logic         wr;
        logic         ack;
        logic [31:0]  addr;
        logic [63:0]  bi;
        logic [255:0] li;
        logic         e_rd;
        logic         e_wr;
        logic         e_resp;
        logic [31:0]  e_addr;
        logic         chk_addr;
        logic [63:0]  e_bo;
        logic         chk_bo;
        logic [255:0] e_line;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mkv(
        input string nm, input logic rd, input logic wr, input logic ack,
        input logic [31:0] addr, input logic [63:0] bi, input logic [255:0] li,
        input logic e_rd, input logic e_wr, input logic e_resp,
        input logic [31:0] e_addr, input logic chk_addr,
        input logic [63:0] e_bo, input logic chk_bo, input logic [255:0] e_line);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.ack = ack; v.addr = addr;
        v.bi = bi; v.li = li; v.e_rd = e_rd; v.e_wr = e_wr; v.e_resp = e_resp;
        v.e_addr = e_addr; v.chk_addr = chk_addr; v.e_bo = e_bo;
        v.chk_bo = chk_bo; v.e_line = e_line;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Hold the row's inputs for one cycle, then compare after the rising edge
    task automatic run_vec(input vec_t v);
        read_i    = v.rd;
        write_i   = v.wr;
        resp_i    = v.ack;
        address_i = v.addr;
        burst_i   = v.bi;
        line_i    = v.li;
        @(negedge clk);
        chk({v.name, ".read_o"},  256'(read_o),  256'(v.e_rd));
        chk({v.name, ".write_o"}, 256'(write_o), 256'(v.e_wr));
        chk({v.name, ".resp_o"},  256'(resp_o),  256'(v.e_resp));
        chk({v.name, ".line_o"},  line_o,        v.e_line);
        if (v.chk_addr) chk({v.name, ".address_o"}, 256'(address_o), 256'(v.e_addr));
        if (v.chk_bo)   chk({v.name, ".burst_o"},   256'(burst_o),   256'(v.e_bo));
    endtask

`ifdef CACHELINE_ADAPTOR_PERF_EN
    // Unchecked transaction used only to advance the perf counters
    task automatic raw_txn(input logic is_wr);
        read_i  = ~is_wr;
        write_i = is_wr;
        resp_i  = 1'b0;
        @(negedge clk);
        resp_i = 1'b1;
        repeat (4) @(negedge clk);
        resp_i  = 1'b0;
        read_i  = 1'b0;
        write_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask
`endif

    localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] WB = 64'hBBBB_BBBB_BBBB_BBBB;
    localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC;
    localparam logic [63:0] WD = 64'hDDDD_DDDD_DDDD_DDDD;
    localparam logic [63:0] S0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] S1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] S2 = 64'h0F0F_0F0F_0F0F_0F0F;
    localparam logic [63:0] S3 = 64'hF0F0_F0F0_F0F0_F0F0;
    localparam logic [63:0] E1 = 64'h5555_0000_0000_0001;
    localparam logic [63:0] E2 = 64'h5555_0000_0000_0002;
    localparam logic [63:0] F1 = 64'h6666_0000_0000_00F1;
    localparam logic [63:0] F2 = 64'h6666_0000_0000_00F2;
    localparam logic [63:0] F3 = 64'h6666_0000_0000_00F3;
    localparam logic [63:0] F4 = 64'h6666_0000_0000_00F4;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rl;
        logic [255:0] wl;
        logic [255:0] sl;
        logic [255:0] fl;
        logic [255:0] z;
        rl = {B4, B3, B2, B1};
        wl = {WD, WC, WB, WA};
        sl = {S3, S2, S1, S0};
        fl = {F4, F3, F2, F1};
        z  = '0;

        // Read: one-cycle memory turnaround then four consecutive beats
        tbl.push_back(mkv("rd_req",  1,0,0, 32'h0000_1234, 64'h0, z, 1,0,0, 32'h0000_1220,1, 64'h0,1, z));
        tbl.push_back(mkv("rd_wait", 1,0,0, 32'h0000_1234, 64'h0, z, 1,0,0, 32'h0000_1220,1, 64'h0,1, z));
        tbl.push_back(mkv("rd_b0",   1,0,1, 32'h0000_1234, B1, z, 1,0,0, 32'h0000_1220,1, 64'h0,1, {192'h0, B1}));
        tbl.push_back(mkv("rd_b1",   1,0,1, 32'h0000_1234, B2, z, 1,0,0, 32'h0000_1220,1, 64'h0,1, {128'h0, B2, B1}));
        tbl.push_back(mkv("rd_b2",   1,0,1, 32'h0000_1234, B3, z, 1,0,0, 32'h0000_1220,1, 64'h0,1, {64'h0, B3, B2, B1}));
        tbl.push_back(mkv("rd_b3",   1,0,1, 32'h0000_1234, B4, z, 0,0,1, 32'h0,0, 64'h0,0, rl));
        tbl.push_back(mkv("rd_done", 1,0,0, 32'h0000_1234, 64'h0, z, 0,0,0, 32'h0,0, 64'h0,0, rl));
        // Spurious acks while idle
        tbl.push_back(mkv("spur0",   0,0,1, 32'h0, JUNK, z, 0,0,0, 32'h0,0, 64'h0,0, rl));
        tbl.push_back(mkv("spur1",   0,0,1, 32'h0, JUNK, z, 0,0,0, 32'h0,0, 64'h0,0, rl));
        tbl.push_back(mkv("spur2",   0,0,1, 32'h0, JUNK, z, 0,0,0, 32'h0,0, 64'h0,0, rl));
        // Write with ack pattern 1,0,0,1,1,0,1; inputs scrambled after acceptance
        tbl.push_back(mkv("wr_req",  0,1,0, 32'h0000_ABCD, 64'h0, wl,  0,1,0, 32'h0000_ABC0,1, WA,1, rl));
        tbl.push_back(mkv("wr_a1",   0,1,1, 32'hFFFF_FFFF, 64'h0, ~wl, 0,1,0, 32'h0000_ABC0,1, WB,1, rl));
        tbl.push_back(mkv("wr_s1",   0,1,0, 32'hFFFF_FFFF, 64'h0, ~wl, 0,1,0, 32'h0000_ABC0,1, WB,1, rl));
        tbl.push_back(mkv("wr_s2",   0,1,0, 32'hFFFF_FFFF, 64'h0, ~wl, 0,1,0, 32'h0000_ABC0,1, WB,1, rl));
        tbl.push_back(mkv("wr_a2",   0,1,1, 32'hFFFF_FFFF, 64'h0, ~wl, 0,1,0, 32'h0000_ABC0,1, WC,1, rl));
        tbl.push_back(mkv("wr_a3",   0,1,1, 32'hFFFF_FFFF, 64'h0, ~wl, 0,1,0, 32'h0000_ABC0,1, WD,1, rl));
        tbl.push_back(mkv("wr_s3",   0,1,0, 32'hFFFF_FFFF, 64'h0, ~wl, 0,1,0, 32'h0000_ABC0,1, WD,1, rl));
        tbl.push_back(mkv("wr_a4",   0,1,1, 32'hFFFF_FFFF, 64'h0, ~wl, 0,0,1, 32'h0,0, 64'h0,0, rl));
        tbl.push_back(mkv("wr_done", 0,1,0, 32'hFFFF_FFFF, 64'h0, ~wl, 0,0,0, 32'h0,0, 64'h0,0, rl));
        tbl.push_back(mkv("wr_idle", 0,0,0, 32'h0, 64'h0, z, 0,0,0, 32'h0,0, 64'h0,0, rl));
        // Read and write together: write wins
        tbl.push_back(mkv("both_req", 1,1,0, 32'h0000_0100, 64'h0, sl, 0,1,0, 32'h0000_0100,1, S0,1, rl));
        tbl.push_back(mkv("both_a1",  1,1,1, 32'h0000_0100, JUNK, sl, 0,1,0, 32'h0000_0100,1, S1,1, rl));
        tbl.push_back(mkv("both_a2",  1,1,1, 32'h0000_0100, JUNK, sl, 0,1,0, 32'h0000_0100,1, S2,1, rl));
        tbl.push_back(mkv("both_a3",  1,1,1, 32'h0000_0100, JUNK, sl, 0,1,0, 32'h0000_0100,1, S3,1, rl));
        tbl.push_back(mkv("both_a4",  1,1,1, 32'h0000_0100, JUNK, sl, 0,0,1, 32'h0,0, 64'h0,0, rl));
        tbl.push_back(mkv("both_dn",  1,1,0, 32'h0000_0100, 64'h0, sl, 0,0,0, 32'h0,0, 64'h0,0, rl));
        tbl.push_back(mkv("both_idl", 0,0,0, 32'h0, 64'h0, z, 0,0,0, 32'h0,0, 64'h0,0, rl));
        // Read interrupted by reset after two beats
        tbl.push_back(mkv("ab_req",  1,0,0, 32'h0000_2000, 64'h0, z, 1,0,0, 32'h0000_2000,1, 64'h0,0, rl));
        tbl.push_back(mkv("ab_b0",   1,0,1, 32'h0000_2000, E1, z, 1,0,0, 32'h0000_2000,1, 64'h0,0, {B4, B3, B2, E1}));
        tbl.push_back(mkv("ab_b1",   1,0,1, 32'h0000_2000, E2, z, 1,0,0, 32'h0000_2000,1, 64'h0,0, {B4, B3, E2, E1}));
        // Fresh read after reset
        tbl.push_back(mkv("fr_req",  1,0,0, 32'h3FFF_FFFF, 64'h0, z, 1,0,0, 32'h3FFF_FFE0,1, 64'h0,1, z));
        tbl.push_back(mkv("fr_b0",   1,0,1, 32'h3FFF_FFFF, F1, z, 1,0,0, 32'h3FFF_FFE0,1, 64'h0,1, {192'h0, F1}));
        tbl.push_back(mkv("fr_b1",   1,0,1, 32'h3FFF_FFFF, F2, z, 1,0,0, 32'h3FFF_FFE0,1, 64'h0,1, {128'h0, F2, F1}));
        tbl.push_back(mkv("fr_b2",   1,0,1, 32'h3FFF_FFFF, F3, z, 1,0,0, 32'h3FFF_FFE0,1, 64'h0,1, {64'h0, F3, F2, F1}));
        tbl.push_back(mkv("fr_b3",   1,0,1, 32'h3FFF_FFFF, F4, z, 0,0,1, 32'h0,0, 64'h0,0, fl));
        tbl.push_back(mkv("fr_done", 0,0,0, 32'h0, 64'h0, z, 0,0,0, 32'h0,0, 64'h0,0, fl));

        // Power-on reset
        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = '0; line_i = '0; burst_i = '0;
        @(negedge clk);
        chk("por.read_o",    256'(read_o),    256'(0));
        chk("por.write_o",   256'(write_o),   256'(0));
        chk("por.resp_o",    256'(resp_o),    256'(0));
        chk("por.line_o",    line_o,          z);
        chk("por.address_o", 256'(address_o), 256'(0));
        chk("por.burst_o",   256'(burst_o),   256'(0));
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].name == "fr_req") begin
                // Asynchronous reset mid-read, observed before any clock edge
                read_i = 1'b0;
                resp_i = 1'b0;
                rst    = 1'b1;
                #1;
                chk("arst.read_o",    256'(read_o),    256'(0));
                chk("arst.resp_o",    256'(resp_o),    256'(0));
                chk("arst.line_o",    line_o,          z);
                chk("arst.address_o", 256'(address_o), 256'(0));
                chk("arst.burst_o",   256'(burst_o),   256'(0));
                @(negedge clk);
                rst = 1'b0;
            end
            run_vec(tbl[i]);
        end

`ifdef CACHELINE_ADAPTOR_PERF_EN
        chk("perf.rd_after_rst", 256'(rd_count), 256'(1));
        chk("perf.wr_after_rst", 256'(wr_count), 256'(0));
        address_i = 32'h0000_4000;
        line_i    = wl;
        burst_i   = B1;
        raw_txn(1'b0);
        raw_txn(1'b0);
        raw_txn(1'b1);
        raw_txn(1'b1);
        chk("perf.rd_count", 256'(rd_count), 256'(3));
        chk("perf.wr_count", 256'(wr_count), 256'(2));
        force dut.r_rd_count = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_rd_count;
        raw_txn(1'b0);
        chk("perf.rd_wrap", 256'(rd_count), 256'(0));
        chk("perf.wr_hold", 256'(wr_count), 256'(2));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
